// File: rtl/cmm_operand_loader.sv
// ============================================================================
// Module   : cmm_operand_loader
// Purpose  : Packs SIZE complex element beats into the operand vector consumed
//            by complex_matrix_mul; checks last-flag framing.
// Option   : CMM_LOADER_DOUBLE_BUF_EN selects a two-bank ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmm_operand_loader #(
    parameter int SIZE         = 8,
    parameter int WIDTH        = 64,
    parameter int NUM_OPERANDS = 4,
    parameter int CNT_W        = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flush_i,
    input  logic                                     s_valid_i,
    output logic                                     s_ready_o,
    input  logic                                     s_last_i,
    input  logic [WIDTH-1:0]                         s_a_re_i,
    input  logic [WIDTH-1:0]                         s_a_im_i,
    input  logic [WIDTH-1:0]                         s_b_re_i,
    input  logic [WIDTH-1:0]                         s_b_im_i,
    output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]  operands_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic                                     err_o,
    output logic                                     busy_o,
    output logic [CNT_W-1:0]                         vec_cnt_o
);

    localparam int                 C_IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(SIZE - 1);

    typedef logic [NUM_OPERANDS-1:0][WIDTH-1:0] elem_t;
    typedef logic [SIZE-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] bank_t;

    logic               rdy_en_q;
    logic [C_IDX_W-1:0] cnt_q, cnt_d;
    logic               err_q;
    logic [CNT_W-1:0]   vec_cnt_q;

    logic  w_in_ready;
    logic  w_out_valid;
    logic  w_accept;
    logic  w_at_end;
    logic  w_complete;
    logic  w_frame_err;
    logic  w_handoff;
    elem_t w_elem;

    // Element layout: slot 0 = a_re ... slot 3 = b_im
    assign w_elem      = {s_b_im_i, s_b_re_i, s_a_im_i, s_a_re_i};
    assign w_accept    = s_valid_i && w_in_ready && !flush_i;
    assign w_at_end    = (cnt_q == C_LAST_IDX);
    assign w_complete  = w_accept && s_last_i && w_at_end;
    assign w_frame_err = w_accept && (s_last_i != w_at_end);
    assign w_handoff   = w_out_valid && out_ready_i && !flush_i;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d = (w_complete || w_frame_err) ? '0 : cnt_q + C_IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_en_q  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            vec_cnt_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
            err_q    <= w_frame_err;
            if (w_handoff && (vec_cnt_q != '1)) begin
                vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CMM_LOADER_DOUBLE_BUF_EN
    bank_t      bank_q [2];
    logic [1:0] full_q, full_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;

    // Hand-off and completion may hit different banks in the same cycle
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (w_handoff) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (w_complete) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (flush_i) begin
            full_d   = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            if (w_accept) begin
                bank_q[wr_sel_q][cnt_q] <= w_elem;
            end
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign w_out_valid = full_q[rd_sel_q];
    assign w_in_ready  = rdy_en_q && !(&full_q);
    assign operands_o  = bank_q[rd_sel_q];
`else
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t state_q, state_d;
    bank_t  bank_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (w_complete) state_d = ST_FULL;
            ST_FULL: if (w_handoff)  state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
        if (flush_i) begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                bank_q[cnt_q] <= w_elem;
            end
        end
    end

    assign w_out_valid = (state_q == ST_FULL);
    assign w_in_ready  = rdy_en_q && (state_q == ST_FILL);
    assign operands_o  = bank_q;
`endif

    assign s_ready_o   = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign err_o       = err_q;
    assign busy_o      = (cnt_q != '0) || w_out_valid;
    assign vec_cnt_o   = vec_cnt_q;

endmodule

`default_nettype wire
